// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings, default frame widths and
// acknowledge levels. Used by both the target engine and the master FSM.
package i2c_pkg;

    localparam int I2C_ADDR_LEN = 7;
    localparam int I2C_DATA_LEN = 8;

    // Level on SDA during the acknowledge slot
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_GET_ADDRESS = 4'd1,
        ST_ADDR_ACK    = 4'd2,
        ST_WRITE_DATA  = 4'd3,
        ST_DATA_ACK    = 4'd4,
        ST_READ_DATA   = 4'd5,
        ST_CHECK_ACK   = 4'd6,
        ST_IGNORE      = 4'd7
    } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus front end: synchronizes SCL/SDA into clk and produces registered
// single-cycle event pulses plus an SDA level aligned with those pulses.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_prev_reg;
    logic                   sda_prev_reg;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s = sda_sync_reg[SYNC_STAGES-1];

    // Synchronizer chains; reset to 1 (idle bus) so reset release makes no edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_in};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
        end
    end

    // Edge detection; pulses and SDA level are registered together so they align
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
            sda_level    <= 1'b1;
            scl_rise     <= 1'b0;
            scl_fall     <= 1'b0;
            start_det    <= 1'b0;
            stop_det     <= 1'b0;
        end else begin
            scl_prev_reg <= scl_s;
            sda_prev_reg <= sda_s;
            sda_level    <= sda_s;
            scl_rise     <= scl_s & ~scl_prev_reg;
            scl_fall     <= ~scl_s & scl_prev_reg;
            start_det    <= scl_s & sda_prev_reg & ~sda_s;
            stop_det     <= scl_s & ~sda_prev_reg & sda_s;
        end
    end

endmodule

// File: rtl/i2c_target_fsm.sv
// I2C target engine: address match, ACK generation, byte reception and
// byte transmission. SDA is only ever pulled low through sda_oe.
module i2c_target_fsm
    import i2c_pkg::*;
#(
    parameter int                  ADDR_LEN    = I2C_ADDR_LEN,
    parameter int                  DATA_LEN    = I2C_DATA_LEN,
    parameter logic [ADDR_LEN-1:0] TARGET_ADDR = 7'h42,
    parameter int                  SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scl_in,
    input  logic                sda_in,
    output logic                sda_oe,
    output logic [DATA_LEN-1:0] rx_data,
    output logic                rx_valid,
    input  logic [DATA_LEN-1:0] tx_data,
    output logic                tx_req,
    output logic                rw,
    output logic                busy
);

    // Bit position of R/W inside the received address byte
    localparam int         RW_POS   = DATA_LEN - ADDR_LEN - 1;
    localparam logic [2:0] CNT_LAST = 3'(DATA_LEN - 1);

    logic sda_level, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_level (sda_level),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e          state_reg, state_next;
    logic [2:0]          cnt_reg, cnt_next;
    logic [DATA_LEN-1:0] shift_reg, shift_next;
    logic                byte_done_reg, byte_done_next;
    logic                ack_seen_reg, ack_seen_next;
    logic                sda_oe_reg, sda_oe_next;
    logic                rw_reg, rw_next;
    logic [DATA_LEN-1:0] rx_data_reg, rx_data_next;
    logic                rx_valid_reg, rx_valid_next;
    logic                tx_req_reg, tx_req_next;

    logic [DATA_LEN-1:0] shifted_in;
    logic                last_bit;
    logic                addr_hit;

    assign shifted_in = {shift_reg[DATA_LEN-2:0], sda_level};
    assign last_bit   = (cnt_reg == CNT_LAST);
    assign addr_hit   = (shift_reg[DATA_LEN-1 -: ADDR_LEN] == TARGET_ADDR);

    // State and datapath registers; reset releases SDA immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            byte_done_reg <= 1'b0;
            ack_seen_reg  <= 1'b0;
            sda_oe_reg    <= 1'b0;
            rw_reg        <= 1'b0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            tx_req_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            byte_done_reg <= byte_done_next;
            ack_seen_reg  <= ack_seen_next;
            sda_oe_reg    <= sda_oe_next;
            rw_reg        <= rw_next;
            rx_data_reg   <= rx_data_next;
            rx_valid_reg  <= rx_valid_next;
            tx_req_reg    <= tx_req_next;
        end
    end

    // Next-state logic: START/STOP override everything, else act on SCL edges
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shift_next     = shift_reg;
        byte_done_next = byte_done_reg;
        ack_seen_next  = ack_seen_reg;
        sda_oe_next    = sda_oe_reg;
        rw_next        = rw_reg;
        rx_data_next   = rx_data_reg;
        rx_valid_next  = 1'b0;
        tx_req_next    = 1'b0;

        if (start_det) begin
            state_next     = ST_GET_ADDRESS;
            cnt_next       = '0;
            byte_done_next = 1'b0;
            sda_oe_next    = 1'b0;
        end else if (stop_det) begin
            state_next  = ST_IDLE;
            sda_oe_next = 1'b0;
        end else begin
            case (state_reg)
                ST_GET_ADDRESS: begin
                    if (scl_rise) begin
                        shift_next = shifted_in;
                        cnt_next   = cnt_reg + 3'd1;
                        if (last_bit) byte_done_next = 1'b1;
                    end else if (scl_fall && byte_done_reg) begin
                        byte_done_next = 1'b0;
                        if (addr_hit) begin
                            state_next  = ST_ADDR_ACK;
                            sda_oe_next = 1'b1;
                            rw_next     = shift_reg[RW_POS];
                        end else begin
                            state_next = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_rise && rw_reg) begin
                        tx_req_next = 1'b1;
                    end else if (scl_fall) begin
                        cnt_next = '0;
                        if (rw_reg) begin
                            state_next  = ST_READ_DATA;
                            shift_next  = tx_data;
                            sda_oe_next = ~tx_data[DATA_LEN-1];
                        end else begin
                            state_next  = ST_WRITE_DATA;
                            sda_oe_next = 1'b0;
                        end
                    end
                end
                ST_WRITE_DATA: begin
                    if (scl_rise) begin
                        shift_next = shifted_in;
                        cnt_next   = cnt_reg + 3'd1;
                        if (last_bit) begin
                            rx_data_next   = shifted_in;
                            rx_valid_next  = 1'b1;
                            byte_done_next = 1'b1;
                        end
                    end else if (scl_fall && byte_done_reg) begin
                        state_next     = ST_DATA_ACK;
                        sda_oe_next    = 1'b1;
                        byte_done_next = 1'b0;
                    end
                end
                ST_DATA_ACK: begin
                    if (scl_fall) begin
                        state_next  = ST_WRITE_DATA;
                        sda_oe_next = 1'b0;
                    end
                end
                ST_READ_DATA: begin
                    if (scl_rise) begin
                        cnt_next = cnt_reg + 3'd1;
                        if (last_bit) byte_done_next = 1'b1;
                    end else if (scl_fall) begin
                        if (byte_done_reg) begin
                            state_next     = ST_CHECK_ACK;
                            sda_oe_next    = 1'b0;
                            byte_done_next = 1'b0;
                        end else begin
                            shift_next  = shift_reg << 1;
                            sda_oe_next = ~shift_reg[DATA_LEN-2];
                        end
                    end
                end
                ST_CHECK_ACK: begin
                    if (scl_rise) begin
                        ack_seen_next = (sda_level == ACK);
                        tx_req_next   = (sda_level == ACK);
                    end else if (scl_fall) begin
                        if (ack_seen_reg) begin
                            state_next  = ST_READ_DATA;
                            shift_next  = tx_data;
                            sda_oe_next = ~tx_data[DATA_LEN-1];
                            cnt_next    = '0;
                        end else begin
                            state_next  = ST_IGNORE;
                            sda_oe_next = 1'b0;
                        end
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                end
                default: begin
                    state_next  = ST_IDLE;
                    sda_oe_next = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe   = sda_oe_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign tx_req   = tx_req_reg;
    assign rw       = rw_reg;
    assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_i2c_target_fsm.sv
// Testbench for i2c_target_fsm: the bench plays the bus master with a
// 16-clk SCL period and keeps a transaction-level model of what the target
// must drive, receive and request.
module tb_i2c_target_fsm;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe, rx_valid, tx_req, rw, busy;
    logic [7:0] rx_data;
    logic       sda_bus;

    // Open-drain bus: either side may pull low
    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_fsm dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_m),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rw       (rw),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         tx_req_cnt = 0;
    logic       exp_oe = 1'b0;
    logic [7:0] exp_rx[$];
    logic [7:0] tx_q[$];
    logic [7:0] fbytes[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle compare: target drive level, received bytes, tx_req count
    initial begin
        forever begin
            @(posedge clk);
            #2;
            check("sda_oe", sda_oe, exp_oe);
            if (rx_valid === 1'b1) begin
                if (exp_rx.size() == 0) check("rx_unexpected", rx_valid, 1'b0);
                else check("rx_data", rx_data, exp_rx.pop_front());
            end
            if (tx_req === 1'b1) tx_req_cnt++;
        end
    end

    // Local byte source answering tx_req
    initial begin
        forever begin
            @(negedge clk);
            if (tx_req === 1'b1) begin
                if (tx_q.size() > 0) tx_data = tx_q.pop_front();
                else tx_data = 8'h00;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    // One bit slot, entered just after SCL fell; drv = target must pull low
    task automatic slot(input logic m_sda, input logic drv, output logic seen);
        repeat (3) @(negedge clk);
        exp_oe = drv;
        repeat (3) @(negedge clk);
        sda_m = m_sda;
        repeat (2) @(negedge clk);
        scl_m = 1'b1;
        repeat (4) @(negedge clk);
        seen = sda_bus;
        repeat (4) @(negedge clk);
        scl_m = 1'b0;
    endtask

    task automatic start_cond();
        repeat (4) @(negedge clk);
        sda_m = 1'b0;
        repeat (4) @(negedge clk);
        scl_m = 1'b0;
    endtask

    task automatic rep_start();
        repeat (3) @(negedge clk);
        exp_oe = 1'b0;
        repeat (3) @(negedge clk);
        sda_m = 1'b1;
        repeat (2) @(negedge clk);
        scl_m = 1'b1;
        repeat (4) @(negedge clk);
        sda_m = 1'b0;
        repeat (4) @(negedge clk);
        scl_m = 1'b0;
    endtask

    // STOP, then busy must still be 1 after 3 clk and 0 after 4 clk
    task automatic stop_cond();
        repeat (3) @(negedge clk);
        exp_oe = 1'b0;
        repeat (3) @(negedge clk);
        sda_m = 1'b0;
        repeat (2) @(negedge clk);
        scl_m = 1'b1;
        repeat (4) @(negedge clk);
        sda_m = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_stop_3clk", busy, 1'b1);
        @(negedge clk);
        check("busy_stop_4clk", busy, 1'b0);
        repeat (8) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic tgt_acks, output logic ack_bit);
        logic s;
        for (int i = 7; i >= 0; i--) slot(b[i], 1'b0, s);
        slot(1'b1, tgt_acks, ack_bit);
    endtask

    task automatic recv_byte(input logic [7:0] exp_b, input logic tgt, input logic m_ack,
                             output logic [7:0] got);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            slot(1'b1, tgt & ~exp_b[i], s);
            got[i] = s;
        end
        slot(m_ack ? ACK : NACK, 1'b0, s);
    endtask

    // Whole transaction after START: address, n data bytes, optional STOP
    task automatic frame(input logic [6:0] addr, input logic rnw, input int n, input logic do_stop);
        logic       matched;
        logic       s;
        logic [7:0] got;
        logic [7:0] expb;
        int         tx0;
        matched = (addr == 7'h42);
        tx0 = tx_req_cnt;
        if (matched && rnw) for (int k = 0; k < n; k++) tx_q.push_back(fbytes[k]);
        send_byte({addr, rnw}, matched, s);
        check("addr_ack", s, matched ? ACK : NACK);
        if (matched) check("rw", rw, rnw);
        for (int k = 0; k < n; k++) begin
            if (!rnw) begin
                if (matched) exp_rx.push_back(fbytes[k]);
                send_byte(fbytes[k], matched, s);
                check("data_ack", s, matched ? ACK : NACK);
            end else begin
                expb = matched ? fbytes[k] : 8'hFF;
                recv_byte(expb, matched, (k != n - 1), got);
                check("read_byte", got, expb);
            end
        end
        check("tx_req_count", tx_req_cnt - tx0, (matched && rnw) ? n : 0);
        check("rx_pending", exp_rx.size(), 0);
        if (do_stop) stop_cond();
    endtask

    initial begin
        logic       s;
        logic [6:0] a;
        repeat (4) @(negedge clk);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_req", tx_req, 1'b0);
        check("rst_rw", rw, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write 0xA5
        fbytes[0] = 8'hA5;
        start_cond();
        check("busy_in_frame", busy, 1'b1);
        frame(7'h42, 1'b0, 1, 1'b1);
        check("t1_rx_data", rx_data, 8'hA5);

        // Read 0x3C, 0x81 with ACK then NACK
        fbytes[0] = 8'h3C;
        fbytes[1] = 8'h81;
        start_cond();
        frame(7'h42, 1'b1, 2, 1'b1);

        // Wrong address: never driven
        fbytes[0] = 8'h5A;
        start_cond();
        frame(7'h43, 1'b0, 1, 1'b1);

        // Write 0x11, repeated START, read
        fbytes[0] = 8'h11;
        start_cond();
        frame(7'h42, 1'b0, 1, 1'b0);
        check("t4_rw_write", rw, 1'b0);
        rep_start();
        fbytes[0] = 8'hC3;
        frame(7'h42, 1'b1, 1, 1'b1);
        check("t4_rw_read", rw, 1'b1);
        check("t4_rx_data", rx_data, 8'h11);

        // STOP after 4 data bits
        start_cond();
        send_byte({7'h42, 1'b0}, 1'b1, s);
        check("t5_addr_ack", s, ACK);
        for (int i = 0; i < 4; i++) slot(i[0], 1'b0, s);
        stop_cond();
        check("t5_rx_hold", rx_data, 8'h11);

        // Reset while the target drives a 0 data bit
        start_cond();
        tx_q.push_back(8'h3C);
        send_byte({7'h42, 1'b1}, 1'b1, s);
        check("t6_addr_ack", s, ACK);
        repeat (3) @(negedge clk);
        exp_oe = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_oe_before_reset", sda_oe, 1'b1);
        rst_n = 1'b0;
        exp_oe = 1'b0;
        #1;
        check("t6_oe_in_reset", sda_oe, 1'b0);
        tx_q.delete();
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_busy_after_reset", busy, 1'b0);
        fbytes[0] = 8'($urandom);
        start_cond();
        frame(7'h42, 1'b0, 1, 1'b1);

        // Randomized transactions
        for (int t = 0; t < 16; t++) begin
            a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h42;
            for (int k = 0; k < 4; k++) fbytes[k] = 8'($urandom);
            start_cond();
            frame(a, 1'($urandom), $urandom_range(1, 3), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_target_fsm.md
# i2c_target_fsm

I2C target (slave) engine: the responder at the far end of the bus from the master FSM and its SCL generator. Oversamples SCL/SDA on the system clock, detects START/STOP, matches a fixed 7-bit address, ACKs, and either delivers received bytes or shifts out bytes from a local byte source. Drives SDA open-drain only, through an output-enable; never drives SCL, so no clock stretching.

## Interface
- ADDR_LEN, 7, address bits before the R/W bit
- DATA_LEN, 8, data bits per byte
- TARGET_ADDR, 7'h42, own address; compared MSB first
- SYNC_STAGES, 2, synchronizer depth for scl_in/sda_in (≥2)

- clk  input  1  system clock; must be ≥8× SCL frequency
- rst_n  input  1  reset; asynchronous, active-low
- scl_in  input  1  bus SCL level
- sda_in  input  1  bus SDA level
- sda_oe  output  1  1 = pull SDA low; 0 = release
- rx_data  output  DATA_LEN  last byte written by master
- rx_valid  output  1  one-cycle pulse; rx_data valid
- tx_data  input  DATA_LEN  next byte for a master read
- tx_req  output  1  one-cycle pulse; present tx_data
- rw  output  1  R/W bit of the current transfer (1 = read)
- busy  output  1  1 from START until STOP or return to Idle

## Operation
- States, 4-bit: Idle, Get_Address, Addr_ACK, Write_Data, Data_ACK, Read_Data, Check_ACK, Ignore.
- START = synced SDA falls while synced SCL high; STOP = synced SDA rises while SCL high. Both take priority over every state.
- START in any state → Get_Address, bit counter cleared, sda_oe=0 (covers repeated START). STOP in any state → Idle, sda_oe=0.
- SDA sampled at each synced SCL rising edge; sda_oe changes only one cycle after a synced SCL falling edge. All bits MSB first.
- Get_Address: 8 rising edges (7 address + R/W). Next falling edge: match → Addr_ACK with sda_oe=1, rw latched; mismatch → Ignore (no drive until START/STOP).
- Addr_ACK: sda_oe held 1 until the next falling edge; then rw=0 → Write_Data (release), rw=1 → Read_Data (drive MSB of tx shift register).
- Write_Data: on 8th rising edge rx_data updated and rx_valid pulsed; next falling edge → Data_ACK (sda_oe=1). No back-pressure: every received byte is ACKed. Data_ACK → Write_Data on the following falling edge.
- Read_Data: sda_oe = ~shift[MSB]; shift on each falling edge; after 8th bit's falling edge release SDA → Check_ACK.
- Check_ACK: sample SDA at rising edge; 0 (ACK) → Read_Data at next falling edge with a new byte; 1 (NACK) → Ignore, released.
- tx_req pulses at the rising edge of the address ACK (rw=1) and of each master ACK; tx_data is loaded at the following falling edge.
- Width rules: 3-bit bit counter, wraps 7→0 at each byte boundary; address comparison exact, no general-call support.

## Timing
- Reset values: sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, rw=0, busy=0, state Idle; synchronizer flops reset to 1 (idle bus), so no false edge at reset release.
- Pin-to-event latency: SYNC_STAGES+1 clk; sda_oe update a further 1 clk, i.e. 4 clk after SCL falls with defaults. Master T_LOW ≥ 6 clk covers setup.
- tx_data must be stable from tx_req to the next SCL fall (≥ T_HIGH clk).
- Simultaneous START/STOP detect cannot occur (one SDA edge); a START on the same cycle as an SCL edge takes priority.
- Reset mid-transfer: immediate release, Idle, waits for a fresh START.

## Structure
- Shared package i2c_pkg: 4-bit state encodings, ADDR_LEN/DATA_LEN defaults, ACK=0/NACK=1 constants, also used by the master FSM.
- One sub-module, i2c_bus_sync: synchronizers plus scl_rise, scl_fall, start_det and stop_det pulses; the FSM consumes only these pulses.

## Test plan
- Write 0x42+W, data 0xA5, STOP → ACK on both bytes, rx_valid once with rx_data=0xA5, busy falls 4 clk after STOP.
- Read 0x42+R, tx_data=0x3C then 0x81, master ACK then NACK → SDA carries 0x3C, 0x81; two tx_req pulses; Idle after NACK.
- Address 0x43+W → no ACK, sda_oe stays 0 for the whole frame, no rx_valid.
- Write 0x42+W, 0x11, repeated START, 0x42+R → rx_data=0x11, rw switches 0→1, read proceeds.
- STOP after 4 data bits → Idle, no rx_valid, sda_oe=0.
- rst_n low during Read_Data while driving 0 → sda_oe=0 immediately; following 0x42+W frame is ACKed normally.
